osd_cmd_tx: RTL

Hardware initiator for the OSD command bus (io_osd / io_strobe / io_din), running in clk_sys. It takes a single request and serialises it into one bus frame:
- DISABLE: command 0x40.
- ENABLE: command 0x41, or 0x45 plus five parameter words when info mode is used.
- WRITE: command 0x20 | highres<<3 | row, followed by 256 row bytes read from a local buffer.

It lets a core-side controller drive the OSD overlay without the HPS.

---
 rtl/osd_tx_pkg.sv | 47 ++++
 rtl/osd_tx_slot.sv | 59 +++++
 rtl/osd_cmd_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/osd_tx_pkg.sv
// osd_tx_pkg: shared constants, state enum and command helpers
// for the OSD command bus initiator.
package osd_tx_pkg;

    localparam logic [1:0] OP_DISABLE = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;

    localparam logic [7:0] CMD_EN = 8'h40;
    localparam logic [7:0] CMD_WR = 8'h20;

    localparam int INFO_WORDS = 5;
    localparam int ROW_BYTES  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_GAP
    } state_e;

    function automatic logic [7:0] cmd_byte(
        input logic [1:0] op,
        input logic [4:0] row,
        input logic       hr,
        input logic       info
    );
        case (op)
            OP_ENABLE: cmd_byte = CMD_EN | {5'b0, info, 2'b01};
            OP_WRITE:  cmd_byte = CMD_WR | {4'b0, hr, 3'b0}
                                         | {3'b0, row};
            default:   cmd_byte = CMD_EN;
        endcase
    endfunction

    function automatic logic [8:0] n_words(
        input logic [1:0] op,
        input logic       info
    );
        case (op)
            OP_WRITE:  n_words = 9'(ROW_BYTES);
            OP_ENABLE: n_words = info ? 9'(INFO_WORDS) : 9'd0;
            default:   n_words = 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/osd_tx_slot.sv
// osd_tx_slot: word-slot timer, STB_LO low cycles then STB_HI
// high cycles; chains slots back to back while more=1.
module osd_tx_slot
#(
    parameter int STB_LO = 2,
    parameter int STB_HI = 2
)
(
    input  logic clk_sys,
    input  logic reset,
    input  logic start,
    input  logic more,
    output logic strobe,
    output logic slot_first,
    output logic slot_last
);

    localparam int L  = STB_LO + STB_HI;
    localparam int CW = $clog2(L);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == CW'(L - 1)) begin
                cnt_d    = '0;
                active_d = more;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Strobe is registered so it changes cleanly with io_din.
        strobe_d = active_d && (cnt_d >= CW'(STB_LO));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe     = strobe_q;
    assign slot_first = active_q && (cnt_q == '0);
    assign slot_last  = active_q && (cnt_q == CW'(L - 1));

endmodule

// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: serialises one DISABLE/ENABLE/WRITE request into an
// OSD bus frame. Info-mode ENABLE is built only with OSD_TX_INFO_EN.
module osd_cmd_tx
    import osd_tx_pkg::*;
#(
    parameter int STB_LO = 2,
    parameter int STB_HI = 2,
    parameter int GAP    = 4
)
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_row,
    input  logic        req_highres,
    input  logic        req_info,
    input  logic [11:0] info_x,
    input  logic [11:0] info_y,
    input  logic [5:0]  info_w,
    input  logic [5:0]  info_h,
    input  logic [1:0]  info_rot,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din
);

    localparam int GW = $clog2(GAP + 1);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          osd_q, osd_d;
    logic [15:0]   din_q, din_d;
    logic [7:0]    rd_addr_q, rd_addr_d;
    logic [8:0]    word_q, word_d;
    logic [8:0]    last_q, last_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_q, wr_d;

    logic          info_en;
    logic [7:0]    nxt;
    logic [15:0]   nxt_word;
    logic          slot_start;
    logic          slot_more;
    logic          slot_first;
    logic          slot_last;

`ifdef OSD_TX_INFO_EN
    logic [11:0] ix_q, ix_d;
    logic [11:0] iy_q, iy_d;
    logic [5:0]  iw_q, iw_d;
    logic [5:0]  ih_q, ih_d;
    logic [1:0]  ir_q, ir_d;

    assign info_en = req_info;

    logic unused_ok;
    assign unused_ok = slot_first;
`else
    assign info_en = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{req_info, info_x, info_y,
                         info_w, info_h, info_rot,
                         slot_first};
`endif

    assign nxt       = word_q[7:0] + 8'd1;
    assign slot_more = (word_q != last_q);

    always_comb begin
        nxt_word = 16'h0000;
        if (wr_q) begin
            nxt_word = {8'h00, rd_data};
        end else begin
`ifdef OSD_TX_INFO_EN
            case (nxt)
                8'd1:    nxt_word = {4'b0, ix_q};
                8'd2:    nxt_word = {4'b0, iy_q};
                8'd3:    nxt_word = {10'b0, iw_q};
                8'd4:    nxt_word = {10'b0, ih_q};
                8'd5:    nxt_word = {14'b0, ir_q};
                default: nxt_word = 16'h0000;
            endcase
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        osd_d      = osd_q;
        din_d      = din_q;
        rd_addr_d  = rd_addr_q;
        word_d     = word_q;
        last_d     = last_q;
        gap_d      = gap_q;
        wr_d       = wr_q;
        slot_start = 1'b0;
`ifdef OSD_TX_INFO_EN
        ix_d = ix_q;
        iy_d = iy_q;
        iw_d = iw_q;
        ih_d = ih_q;
        ir_d = ir_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req && !busy_q && req_op != 2'd3) begin
                    state_d    = ST_CMD;
                    busy_d     = 1'b1;
                    osd_d      = 1'b1;
                    din_d      = {8'h00, cmd_byte(req_op, req_row,
                                                  req_highres,
                                                  info_en)};
                    rd_addr_d  = 8'd0;
                    word_d     = 9'd0;
                    last_d     = n_words(req_op, info_en);
                    wr_d       = (req_op == OP_WRITE);
                    slot_start = 1'b1;
`ifdef OSD_TX_INFO_EN
                    ix_d = info_x;
                    iy_d = info_y;
                    iw_d = info_w;
                    ih_d = info_h;
                    ir_d = info_rot;
`endif
                end
            end
            ST_CMD, ST_DATA: begin
                if (slot_last) begin
                    if (word_q == last_q) begin
                        state_d = ST_GAP;
                        osd_d   = 1'b0;
                        gap_d   = '0;
                    end else begin
                        // rd_data holds byte word_q, fetched last slot.
                        state_d = ST_DATA;
                        word_d  = word_q + 9'd1;
                        din_d   = nxt_word;
                        if (wr_q) begin
                            rd_addr_d = nxt;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            osd_q     <= 1'b0;
            din_q     <= 16'h0000;
            rd_addr_q <= 8'd0;
            word_q    <= 9'd0;
            last_q    <= 9'd0;
            gap_q     <= '0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            osd_q     <= osd_d;
            din_q     <= din_d;
            rd_addr_q <= rd_addr_d;
            word_q    <= word_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            wr_q      <= wr_d;
        end
    end

`ifdef OSD_TX_INFO_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ix_q <= '0;
            iy_q <= '0;
            iw_q <= '0;
            ih_q <= '0;
            ir_q <= '0;
        end else begin
            ix_q <= ix_d;
            iy_q <= iy_d;
            iw_q <= iw_d;
            ih_q <= ih_d;
            ir_q <= ir_d;
        end
    end
`endif

    osd_tx_slot #(
        .STB_LO (STB_LO),
        .STB_HI (STB_HI)
    ) u_slot (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .start      (slot_start),
        .more       (slot_more),
        .strobe     (io_strobe),
        .slot_first (slot_first),
        .slot_last  (slot_last)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign io_osd  = osd_q;
    assign io_din  = din_q;
    assign rd_addr = rd_addr_q;

endmodule
